// File: rtl/nd_row_sigma.sv
// Off-diagonal partial sum for one tridiagonal Jacobi sweep. For each row it
// fetches a[i][i-1], a[i][i+1], x[i-1] and x[i+1], then emits their Q-format dot product.
module nd_row_sigma #(
    parameter int element_width       = 32,
    parameter int frac_bits           = 16,
    parameter int no_of_non_diagonals = 2,
    parameter int A_mem_height        = 64,
    localparam int RW                 = $clog2(A_mem_height)
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    input  logic [RW:0]                                   num_rows,
    output logic                                          readMem,
    output logic [RW-1:0]                                 row_num,
    input  logic [element_width*no_of_non_diagonals-1:0]  nd_elements,
    input  logic                                          nd_finish,
    output logic                                          x_rd_en,
    output logic [RW-1:0]                                 x_rd_addr,
    input  logic [element_width-1:0]                      x_rd_data,
    output logic [element_width-1:0]                      sigma,
    output logic [RW-1:0]                                 sigma_row,
    output logic                                          sigma_valid,
    input  logic                                          sigma_ready,
    output logic                                          busy,
    output logic                                          done
);

    typedef enum logic [2:0] {IDLE, REQ, XLO, XHI, CALC, OUT} state_t;

    localparam logic [RW:0]   MAX_ROWS = (RW+1)'(A_mem_height);
    localparam logic [RW:0]   ONE_N    = 1;
    localparam logic [RW-1:0] ONE_R    = 1;

    state_t                      state;
    logic [RW:0]                 rows_q;
    logic [RW-1:0]               row;
    logic [element_width-1:0]    a_lo;
    logic [element_width-1:0]    a_hi;
    logic [element_width-1:0]    x_lo;

    logic                        first_row;
    logic                        last_row;
    logic                        start_ok;
    logic [element_width-1:0]    x_hi;
    logic [2*element_width-1:0]  ext_a_lo;
    logic [2*element_width-1:0]  ext_a_hi;
    logic [2*element_width-1:0]  ext_x_lo;
    logic [2*element_width-1:0]  ext_x_hi;
    logic signed [2*element_width-1:0] p_lo;
    logic signed [2*element_width-1:0] p_hi;
    logic [element_width-1:0]    sigma_next;

    assign first_row = (row == '0);
    assign last_row  = ({1'b0, row} == (rows_q - ONE_N));
    assign start_ok  = (num_rows != '0) && (num_rows <= MAX_ROWS);

    // Full-width signed products; shifting then truncating keeps bits
    // [frac_bits +: element_width], and the sum wraps with no saturation.
    always_comb begin
        x_hi       = last_row ? '0 : x_rd_data;
        ext_a_lo   = {{element_width{a_lo[element_width-1]}}, a_lo};
        ext_a_hi   = {{element_width{a_hi[element_width-1]}}, a_hi};
        ext_x_lo   = {{element_width{x_lo[element_width-1]}}, x_lo};
        ext_x_hi   = {{element_width{x_hi[element_width-1]}}, x_hi};
        p_lo       = $signed(ext_a_lo) * $signed(ext_x_lo);
        p_hi       = $signed(ext_a_hi) * $signed(ext_x_hi);
        sigma_next = element_width'(p_lo >>> frac_bits) + element_width'(p_hi >>> frac_bits);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rows_q      <= '0;
            row         <= '0;
            a_lo        <= '0;
            a_hi        <= '0;
            x_lo        <= '0;
            readMem     <= 1'b0;
            row_num     <= '0;
            x_rd_en     <= 1'b0;
            x_rd_addr   <= '0;
            sigma       <= '0;
            sigma_row   <= '0;
            sigma_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && start_ok) begin
                        rows_q  <= num_rows;
                        row     <= '0;
                        row_num <= '0;
                        readMem <= 1'b1;
                        busy    <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (nd_finish) begin
                        a_lo      <= nd_elements[element_width-1:0];
                        a_hi      <= nd_elements[2*element_width-1:element_width];
                        readMem   <= 1'b0;
                        x_rd_en   <= !first_row;
                        x_rd_addr <= first_row ? '0 : row - ONE_R;
                        state     <= XLO;
                    end
                end
                XLO: begin
                    x_rd_en   <= !last_row;
                    x_rd_addr <= last_row ? '0 : row + ONE_R;
                    state     <= XHI;
                end
                XHI: begin
                    x_lo      <= first_row ? '0 : x_rd_data;
                    x_rd_en   <= 1'b0;
                    x_rd_addr <= '0;
                    state     <= CALC;
                end
                CALC: begin
                    sigma       <= sigma_next;
                    sigma_row   <= row;
                    sigma_valid <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (sigma_ready) begin
                        sigma_valid <= 1'b0;
                        if (last_row) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            row     <= row + ONE_R;
                            row_num <= row + ONE_R;
                            readMem <= 1'b1;
                            state   <= REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nd_row_sigma.sv
// Randomised bench for nd_row_sigma: ND and x memories modelled as arrays, sigma
// recomputed from the row formula with plain integer arithmetic.
module tb_nd_row_sigma;

    localparam int W  = 32;
    localparam int H  = 64;
    localparam int RW = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [RW:0]       num_rows;
    logic              readMem;
    logic [RW-1:0]     row_num;
    logic [2*W-1:0]    nd_elements;
    logic              nd_finish;
    logic              x_rd_en;
    logic [RW-1:0]     x_rd_addr;
    logic [W-1:0]      x_rd_data;
    logic [W-1:0]      sigma;
    logic [RW-1:0]     sigma_row;
    logic              sigma_valid;
    logic              sigma_ready;
    logic              busy;
    logic              done;

    nd_row_sigma dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
        .readMem(readMem), .row_num(row_num), .nd_elements(nd_elements),
        .nd_finish(nd_finish), .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr),
        .x_rd_data(x_rd_data), .sigma(sigma), .sigma_row(sigma_row),
        .sigma_valid(sigma_valid), .sigma_ready(sigma_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [2*W-1:0] nd_mem [H];
    logic [W-1:0]   x_mem  [H];

    int vectors = 0;
    int miscompares = 0;

    int nd_delay = 0;
    bit nd_rand  = 1'b0;
    int rd_stall = 0;
    bit rd_rand  = 1'b0;
    int cur_n    = 1;

    int          cyc = 0;
    int          got_row [$];
    logic [W-1:0] got_sig [$];
    int          got_cyc [$];
    int          req_cyc [$];
    int          x_addr_log [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          start_cyc = -1;
    int          rm_cycles = 0;
    int          stab_viol = 0;
    int          bound_viol = 0;

    function automatic logic [W-1:0] fx_mul(input logic [W-1:0] a, input logic [W-1:0] x);
        longint p;
        p = longint'($signed(a)) * longint'($signed(x));
        return W'(p >>> 16);
    endfunction

    function automatic logic [W-1:0] ref_sigma(input int i, input int n);
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        lo = (i > 0)     ? fx_mul(nd_mem[i][W-1:0], x_mem[i-1])     : '0;
        hi = (i < n - 1) ? fx_mul(nd_mem[i][2*W-1:W], x_mem[i+1])   : '0;
        return lo + hi;
    endfunction

    // Passive observer: records handshakes, requests, x reads and handshake stability.
    initial begin
        logic         prev_stall;
        logic         prev_rm;
        logic [W-1:0] prev_sig;
        logic [RW-1:0] prev_row;
        prev_stall = 1'b0;
        prev_rm    = 1'b0;
        prev_sig   = '0;
        prev_row   = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_rm    = 1'b0;
            end else begin
                if (start && !busy) start_cyc = cyc;
                if (readMem) rm_cycles++;
                if (readMem && !prev_rm) req_cyc.push_back(cyc);
                prev_rm = readMem;
                if (x_rd_en) begin
                    x_addr_log.push_back(int'(x_rd_addr));
                    if (int'(x_rd_addr) >= cur_n) bound_viol++;
                end else if (x_rd_addr != '0) begin
                    bound_viol++;
                end
                if (prev_stall && (!sigma_valid || sigma !== prev_sig || sigma_row !== prev_row))
                    stab_viol++;
                prev_stall = sigma_valid && !sigma_ready;
                prev_sig   = sigma;
                prev_row   = sigma_row;
                if (sigma_valid && sigma_ready) begin
                    got_row.push_back(int'(sigma_row));
                    got_sig.push_back(sigma);
                    got_cyc.push_back(cyc);
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    // ND memory: answers a request after nd_delay wait cycles.
    initial begin
        int nd_cnt;
        int nd_cur;
        nd_cnt = 0;
        nd_cur = 0;
        nd_finish = 1'b0;
        nd_elements = '0;
        forever begin
            @(negedge clk);
            if (readMem && rst_n) begin
                if (nd_cnt >= nd_cur) begin
                    nd_finish   = 1'b1;
                    nd_elements = nd_mem[row_num];
                end else begin
                    nd_cnt++;
                    nd_finish = 1'b0;
                end
            end else begin
                nd_finish   = 1'b0;
                nd_cnt      = 0;
                nd_cur      = nd_rand ? int'($urandom_range(0, 3)) : nd_delay;
                nd_elements = {$urandom, $urandom};
            end
        end
    end

    // x memory: one-cycle read latency, garbage when not enabled.
    initial begin
        logic          xe;
        logic [RW-1:0] xa;
        x_rd_data = 32'hDEADBEEF;
        forever begin
            @(negedge clk);
            xe = x_rd_en;
            xa = x_rd_addr;
            @(posedge clk);
            #1;
            x_rd_data = xe ? x_mem[xa] : $urandom;
        end
    end

    // Consumer: holds sigma_ready low for rd_stall cycles of each OUT.
    initial begin
        int rd_cnt;
        int rd_cur;
        rd_cnt = 0;
        rd_cur = 0;
        sigma_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (sigma_valid) begin
                if (rd_cnt < rd_cur) begin
                    sigma_ready = 1'b0;
                    rd_cnt++;
                end else begin
                    sigma_ready = 1'b1;
                end
            end else begin
                rd_cnt = 0;
                rd_cur = rd_rand ? int'($urandom_range(0, 3)) : rd_stall;
                sigma_ready = (rd_cur == 0);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1);
    end

    task automatic clear_log();
        got_row.delete();
        got_sig.delete();
        got_cyc.delete();
        req_cyc.delete();
        x_addr_log.delete();
        done_cnt   = 0;
        rm_cycles  = 0;
        stab_viol  = 0;
        bound_viol = 0;
        start_cyc  = -1;
    endtask

    task automatic do_start(input int n);
        @(posedge clk);
        #1;
        num_rows = (RW+1)'(n);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0;
        num_rows = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({readMem, row_num, x_rd_en, x_rd_addr, sigma, sigma_row, sigma_valid, busy, done} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs got=%h exp=0",
                     {readMem, row_num, x_rd_en, x_rd_addr, sigma, sigma_row, sigma_valid, busy, done});
        end
        #2 rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, readMem, sigma_valid} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_release got=%b exp=000", {busy, readMem, sigma_valid});
        end
    endtask

    task automatic test_interior();
        bit to;
        clear_log();
        cur_n = 3; nd_rand = 0; nd_delay = 0; rd_rand = 0; rd_stall = 0;
        for (int i = 0; i < 3; i++) begin
            nd_mem[i] = {$urandom, $urandom};
            x_mem[i]  = $urandom;
        end
        nd_mem[1] = {32'h00020000, 32'h00010000};
        x_mem[0]  = 32'h00030000;
        x_mem[2]  = 32'h00008000;
        do_start(3);
        wait_done(200, to);
        vectors++;
        if (to || got_sig.size() != 3) begin
            miscompares++;
            $display("[TB] FAIL interior_count got=%0d exp=3 timeout=%0b", got_sig.size(), to);
        end
        for (int k = 0; k < got_sig.size(); k++) begin
            vectors++;
            if (got_row[k] != k || got_sig[k] !== ref_sigma(k, 3)) begin
                miscompares++;
                $display("[TB] FAIL interior_sigma row=%0d got=%h exp=%h", got_row[k], got_sig[k], ref_sigma(k, 3));
            end
            if (k < req_cyc.size()) begin
                vectors++;
                if (got_cyc[k] - req_cyc[k] + 1 != 5) begin
                    miscompares++;
                    $display("[TB] FAIL interior_latency row=%0d got=%0d exp=5", k, got_cyc[k] - req_cyc[k] + 1);
                end
            end
        end
        if (got_sig.size() > 1) begin
            vectors++;
            if (got_sig[1] !== 32'h00040000) begin
                miscompares++;
                $display("[TB] FAIL interior_row1 got=%h exp=00040000", got_sig[1]);
            end
        end
        if (req_cyc.size() > 0) begin
            vectors++;
            if (req_cyc[0] - start_cyc != 1) begin
                miscompares++;
                $display("[TB] FAIL start_to_readMem got=%0d exp=1", req_cyc[0] - start_cyc);
            end
        end
        if (got_cyc.size() == 3) begin
            vectors++;
            if (done_cyc - got_cyc[2] != 1 || done_cnt != 1) begin
                miscompares++;
                $display("[TB] FAIL interior_done delay=%0d count=%0d exp=1/1", done_cyc - got_cyc[2], done_cnt);
            end
        end
    endtask

    task automatic test_boundary();
        bit to;
        bit bad;
        logic [W-1:0] exp_sig [3];
        int exp_x [4];
        exp_sig[0] = 32'h00020000; exp_sig[1] = 32'h00040000; exp_sig[2] = 32'h00020000;
        exp_x[0] = 1; exp_x[1] = 0; exp_x[2] = 2; exp_x[3] = 1;
        clear_log();
        cur_n = 3;
        for (int i = 0; i < 3; i++) begin
            nd_mem[i] = {32'h00010000, 32'h00010000};
            x_mem[i]  = W'((i + 1) << 16);
        end
        do_start(3);
        wait_done(200, to);
        vectors++;
        if (to || got_sig.size() != 3) begin
            miscompares++;
            $display("[TB] FAIL boundary_count got=%0d exp=3 timeout=%0b", got_sig.size(), to);
        end
        for (int k = 0; k < got_sig.size() && k < 3; k++) begin
            vectors++;
            if (got_sig[k] !== exp_sig[k]) begin
                miscompares++;
                $display("[TB] FAIL boundary_sigma row=%0d got=%h exp=%h", k, got_sig[k], exp_sig[k]);
            end
        end
        bad = (x_addr_log.size() != 4);
        for (int k = 0; k < x_addr_log.size() && k < 4; k++)
            if (x_addr_log[k] != exp_x[k]) bad = 1'b1;
        vectors++;
        if (bad || bound_viol != 0) begin
            miscompares++;
            $display("[TB] FAIL boundary_xreads reads=%0d bound_viol=%0d exp=4/0", x_addr_log.size(), bound_viol);
        end
        vectors++;
        if (done_cnt != 1) begin
            miscompares++;
            $display("[TB] FAIL boundary_done got=%0d exp=1", done_cnt);
        end
    endtask

    task automatic test_negative();
        bit to;
        clear_log();
        cur_n = 2;
        nd_mem[0] = {$urandom, $urandom};
        nd_mem[1] = {$urandom, 32'hFFFF0000};
        x_mem[0]  = 32'h00018000;
        x_mem[1]  = $urandom;
        do_start(2);
        wait_done(200, to);
        vectors++;
        if (to || got_sig.size() != 2 || got_sig[1] !== 32'hFFFE8000 || got_sig[0] !== ref_sigma(0, 2)) begin
            miscompares++;
            $display("[TB] FAIL negative_product count=%0d row1 got=%h exp=fffe8000", got_sig.size(), got_sig[1]);
        end
        clear_log();
        cur_n = 3;
        nd_mem[1] = {32'h7FFF0000, 32'h7FFF0000};
        x_mem[0]  = 32'h00020000;
        x_mem[2]  = 32'h00020000;
        do_start(3);
        wait_done(200, to);
        vectors++;
        if (to || got_sig.size() != 3 || got_sig[1] !== 32'hFFFC0000) begin
            miscompares++;
            $display("[TB] FAIL wrap_sum count=%0d row1 got=%h exp=fffc0000", got_sig.size(), got_sig[1]);
        end
    endtask

    task automatic test_stalls();
        bit to;
        clear_log();
        cur_n = 2; nd_delay = 4; rd_stall = 3;
        for (int i = 0; i < 2; i++) begin
            nd_mem[i] = {$urandom, $urandom};
            x_mem[i]  = $urandom;
        end
        do_start(2);
        repeat (2) @(posedge clk);
        do_start(5);
        repeat (10) @(posedge clk);
        do_start(5);
        wait_done(300, to);
        repeat (5) @(negedge clk);
        vectors++;
        if (to || got_sig.size() != 2 || req_cyc.size() != 2 || done_cnt != 1) begin
            miscompares++;
            $display("[TB] FAIL stall_sweep rows=%0d reqs=%0d done=%0d exp=2/2/1", got_sig.size(), req_cyc.size(), done_cnt);
        end
        for (int k = 0; k < got_sig.size() && k < req_cyc.size(); k++) begin
            vectors++;
            if (got_cyc[k] - req_cyc[k] + 1 != 12 || got_sig[k] !== ref_sigma(k, 2)) begin
                miscompares++;
                $display("[TB] FAIL stall_row row=%0d latency=%0d exp=12 got=%h exp=%h",
                         k, got_cyc[k] - req_cyc[k] + 1, got_sig[k], ref_sigma(k, 2));
            end
        end
        vectors++;
        if (rm_cycles != 10 || stab_viol != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall_hold readMem_cycles=%0d exp=10 unstable=%0d busy=%b", rm_cycles, stab_viol, busy);
        end
        nd_delay = 0; rd_stall = 0;
    endtask

    task automatic test_random();
        bit to;
        bit bad;
        int n;
        int exp_x [$];
        nd_rand = 1; rd_rand = 1;
        for (int s = 0; s < 6; s++) begin
            clear_log();
            n = int'($urandom_range(1, 8));
            cur_n = n;
            for (int i = 0; i < n; i++) begin
                nd_mem[i] = {$urandom, $urandom};
                x_mem[i]  = $urandom;
            end
            exp_x.delete();
            for (int i = 0; i < n; i++) begin
                if (i > 0) exp_x.push_back(i - 1);
                if (i < n - 1) exp_x.push_back(i + 1);
            end
            do_start(n);
            wait_done(400, to);
            vectors++;
            if (to || got_sig.size() != n || done_cnt != 1) begin
                miscompares++;
                $display("[TB] FAIL random_sweep n=%0d rows=%0d done=%0d timeout=%0b", n, got_sig.size(), done_cnt, to);
            end
            for (int k = 0; k < got_sig.size(); k++) begin
                vectors++;
                if (got_row[k] != k || got_sig[k] !== ref_sigma(k, n)) begin
                    miscompares++;
                    $display("[TB] FAIL random_sigma n=%0d row=%0d got=%h exp=%h", n, got_row[k], got_sig[k], ref_sigma(k, n));
                end
            end
            bad = (x_addr_log.size() != exp_x.size());
            for (int k = 0; k < x_addr_log.size() && k < exp_x.size(); k++)
                if (x_addr_log[k] != exp_x[k]) bad = 1'b1;
            vectors++;
            if (bad || bound_viol != 0 || stab_viol != 0) begin
                miscompares++;
                $display("[TB] FAIL random_protocol n=%0d reads=%0d exp=%0d bound=%0d unstable=%0d",
                         n, x_addr_log.size(), exp_x.size(), bound_viol, stab_viol);
            end
        end
        nd_rand = 0; rd_rand = 0;
    endtask

    task automatic test_reset_mid();
        bit to;
        bit found;
        clear_log();
        cur_n = 5;
        for (int i = 0; i < 5; i++) begin
            nd_mem[i] = {$urandom, $urandom};
            x_mem[i]  = $urandom;
        end
        do_start(5);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (readMem && row_num == 6'd2) begin
                found = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (!found || x_rd_en !== 1'b1 || x_rd_addr !== 6'd3) begin
            miscompares++;
            $display("[TB] FAIL midreset_xhi found=%0b en=%b addr=%0d exp=1/3", found, x_rd_en, x_rd_addr);
        end
        #2 rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({readMem, row_num, x_rd_en, x_rd_addr, sigma, sigma_row, sigma_valid, busy, done} !== '0 || done_cnt != 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_outputs got=%h exp=0 done=%0d",
                     {readMem, row_num, x_rd_en, x_rd_addr, sigma, sigma_row, sigma_valid, busy, done}, done_cnt);
        end
        #2 rst_n = 1'b1;
        clear_log();
        cur_n = 1;
        nd_mem[0] = {$urandom | 32'h1, $urandom | 32'h1};
        do_start(1);
        wait_done(200, to);
        vectors++;
        if (to || got_sig.size() != 1 || got_sig[0] !== 32'h0 || got_row[0] != 0 || done_cnt != 1) begin
            miscompares++;
            $display("[TB] FAIL single_row rows=%0d sigma=%h exp=0 done=%0d", got_sig.size(), got_sig[0], done_cnt);
        end
    endtask

    task automatic test_illegal();
        clear_log();
        do_start(0);
        repeat (5) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || rm_cycles != 0) begin
            miscompares++;
            $display("[TB] FAIL illegal_zero busy=%b readMem_cycles=%0d exp=0/0", busy, rm_cycles);
        end
        do_start(H + 1);
        repeat (5) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || rm_cycles != 0 || req_cyc.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL illegal_over busy=%b readMem_cycles=%0d exp=0/0", busy, rm_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_interior();
        test_boundary();
        test_negative();
        test_stalls();
        test_random();
        test_reset_mid();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nd_row_sigma.md
# nd_row_sigma

Downstream consumer of the non-diagonal (ND) element memory in the tridiagonal Jacobi datapath. For each row i in 0..num_rows-1 it requests the row's two off-diagonal coefficients from the ND memory. It fetches neighbour unknowns x[i-1] and x[i+1] from the x-vector memory, and computes sigma_i = a[i][i-1]·x[i-1] + a[i][i+1]·x[i+1] in signed fixed point. It then hands sigma_i to the diagonal-divide stage over a valid/ready handshake.

## Interface
Parameters:
- element_width, 32: width of one coefficient / x value / sigma, signed two's complement.
- frac_bits, 16: fractional bits of the fixed-point format.
- no_of_non_diagonals, 2: elements per ND word. Slot 0 (bits [element_width-1:0]) is a[i][i-1]. Slot 1 is a[i][i+1].
- A_mem_height, 64: maximum rows. RW = $clog2(A_mem_height).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- num_rows  in  RW+1  rows in this sweep; sampled on accepted start.
- readMem  out  1  ND memory read request.
- row_num  out  RW  row index presented to ND memory.
- nd_elements  in  element_width·no_of_non_diagonals  ND word.
- nd_finish  in  1  ND memory read complete; nd_elements valid while high.
- x_rd_en  out  1  x-memory read enable.
- x_rd_addr  out  RW  x-memory address.
- x_rd_data  in  element_width  x-memory data, valid the cycle after x_rd_en.
- sigma  out  element_width  off-diagonal sum.
- sigma_row  out  RW  row of current sigma.
- sigma_valid  out  1  sigma/sigma_row valid.
- sigma_ready  in  1  consumer accepts.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse after last row accepted.

## Operation
- FSM states: IDLE, REQ, XLO, XHI, CALC, OUT.
- **IDLE:**
  - On start with 1 ≤ num_rows ≤ A_mem_height: latch num_rows, set row=0, go to REQ.
  - start with num_rows = 0 or above A_mem_height is ignored.
  - start is ignored in every state other than IDLE.
- **REQ:**
  - readMem=1, row_num=row.
  - Stay until nd_finish=1. In that cycle, capture nd_elements into a_lo/a_hi and go to XLO.
- **XLO:** x_rd_addr=row-1, x_rd_en=1 only if row>0. Go to XHI.
- **XHI:**
  - Capture x_rd_data into x_lo if row>0, else x_lo=0.
  - Drive x_rd_addr=row+1, x_rd_en=1 only if row<num_rows-1.
  - Go to CALC.
- **CALC:**
  - x_hi = x_rd_data if row<num_rows-1, else 0.
  - p_lo = a_lo·x_lo and p_hi = a_hi·x_hi, each a full 2·element_width signed product.
  - Each product is arithmetic-shifted right by frac_bits (truncation toward −∞), then truncated to element_width.
  - sigma = p_lo + p_hi, wrapping modulo 2^element_width. No saturation.
  - Register sigma and sigma_row=row, then go to OUT.
- **OUT:**
  - sigma_valid=1. sigma and sigma_row stay stable until accepted.
  - On sigma_ready=1: if row = num_rows-1, pulse done and go to IDLE; else row+1 and go to REQ.
- **Boundary rows:**
  - Row 0 ignores ND slot 0.
  - The last row ignores ND slot 1.
  - Neither row issues the corresponding x read.
  - num_rows=1: sigma=0 for row 0.
- x_rd_addr is driven 0 whenever x_rd_en=0.
- busy=1 in every state except IDLE.

## Timing
- Reset values:
  - state=IDLE.
  - readMem=0, row_num=0, x_rd_en=0, x_rd_addr=0.
  - sigma=0, sigma_row=0, sigma_valid=0, busy=0, done=0.
  - All internal registers are 0.
- Assertion of rst_n=0 mid-sweep aborts immediately: all outputs return to reset values and no done pulse is issued.
- readMem is a level. It rises on entry to REQ and falls on the edge that captures nd_finish. There is no second request for the same row.
- Per-row latency, with nd_finish high on the first REQ cycle and sigma_ready held high, is 5 cycles: REQ, XLO, XHI, CALC, OUT. Each cycle of nd_finish delay or sigma_ready backpressure adds one cycle.
- start→readMem: 1 cycle.
- done is asserted in the cycle after the final OUT handshake, coincident with IDLE.
- sigma_valid never drops without a handshake.

## Test plan
- **Interior row:** Q16.16, num_rows=3, row 1 ND = {a_hi=0x00020000, a_lo=0x00010000}, x[0]=0x00030000, x[2]=0x00008000 → sigma_row=1, sigma=0x00040000 (1·3 + 2·0.5).
- **Boundary rows:** num_rows=3, all ND slots 0x00010000, x = {1.0, 2.0, 3.0} → sigma row0=0x00020000, row2=0x00020000. No x_rd_en for addr −1 or 3. done exactly once after the row-2 handshake.
- **Negative / wrap:** a_lo=0xFFFF0000 (−1.0), x_lo=0x00018000 → p_lo=0xFFFE8000. Also a_lo=a_hi=0x7FFF0000 with x=0x00020000 each → sigma wraps to 0xFFFC0000.
- **Stalls:** nd_finish delayed 4 cycles and sigma_ready low 3 cycles → readMem held 5 cycles, sigma stable, row latency 12 cycles. start pulses during busy are ignored.
- **Reset mid-sweep:** rst_n low during XHI of row 2 of 5 → outputs at reset values next cycle. A new start with num_rows=1 produces sigma=0 and a done pulse.
- **Illegal start:** num_rows=0 and num_rows=A_mem_height+1 → stays IDLE, busy=0, readMem never asserted.
